// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-trigger generator.
package f1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HOLD,
    ST_WAIT_RELEASE
  } trig_state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned TRIG_FLAG_BIT = 0;
  localparam int unsigned TRIG_RAND_LSB = 8;
  localparam int unsigned TRIG_CNT_LSB  = 24;

  // One step of the 16-bit Galois LFSR; a non-zero state never maps to zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, advancing every clock.
module lfsr16
  import f1_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (rst) value <= SEED;
    else     value <= lfsr_next(value);
  end

endmodule

// File: rtl/f1_trigger_gen.sv
// Debounced, stretched start-button trigger word for the F1 CPU (x5).
// Define F1_TRIGGER_LFSR_EN to build the LFSR and capture it into trigger[23:8].
module f1_trigger_gen
  import f1_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES     = 64,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_in,
  output logic [31:0] trigger,
  output logic        press_pulse
);

  localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  // Elaboration-time guard on illegal parameter values.
  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 || LFSR_SEED == 16'h0000) begin : g_param_err
    $error("f1_trigger_gen: illegal DEBOUNCE_CYCLES, HOLD_CYCLES or LFSR_SEED");
  end

  logic             btn_meta;
  logic             sync;
  trig_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             capture_c;
  logic             flag_q;
  logic             pulse_q;
  logic [7:0]       press_cnt_q;
  logic [15:0]      rand_q;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= 1'b0;
      sync     <= 1'b0;
    end else begin
      btn_meta <= btn_in;
      sync     <= btn_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Debounce/hold/release sequencing with one shared counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync) begin
          state_d = ST_DEBOUNCE;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (!sync) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = ST_HOLD;
          cnt_d     = '0;
          capture_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_RELEASE: begin
        // cnt tracks consecutive low samples; any high sample restarts it.
        if (sync) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q      <= 1'b0;
      pulse_q     <= 1'b0;
      press_cnt_q <= 8'h00;
    end else begin
      flag_q  <= (state_d == ST_HOLD);
      pulse_q <= capture_c;
      if (capture_c) press_cnt_q <= press_cnt_q + 8'd1;
    end
  end

`ifdef F1_TRIGGER_LFSR_EN
  logic [15:0] lfsr_value;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_value)
  );

  always_ff @(posedge clk) begin
    if (rst)            rand_q <= 16'h0000;
    else if (capture_c) rand_q <= lfsr_value;
  end
`else
  assign rand_q = 16'h0000;
`endif

  always_comb begin
    trigger                          = 32'h0;
    trigger[TRIG_FLAG_BIT]           = flag_q;
    trigger[TRIG_RAND_LSB +: 16]     = rand_q;
    trigger[TRIG_CNT_LSB +: 8]       = press_cnt_q;
  end

  assign press_pulse = pulse_q;

endmodule

// File: tb/tb_f1_trigger_gen.sv
// Scoreboard bench for f1_trigger_gen: run-length reference model feeds a capture queue.
module tb_f1_trigger_gen;

  localparam int unsigned D    = 4;
  localparam int unsigned H    = 8;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef F1_TRIGGER_LFSR_EN
  localparam bit LFSR_ON = 1'b1;
`else
  localparam bit LFSR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn = 1'b0;
  logic [31:0] trigger;
  logic        press_pulse;

  always #5 clk = ~clk;

  f1_trigger_gen #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .LFSR_SEED       (SEED)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn),
    .trigger     (trigger),
    .press_pulse (press_pulse)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: btn delayed two samples, then run-length rules.
  logic        d1 = 1'b0, d2 = 1'b0, x = 1'b0;
  int          high_run = 0, low_run = 0, hold_left = 0;
  bit          releasing = 1'b0;
  logic [7:0]  cnt_m = 8'h00;
  logic [15:0] rand_m = 16'h0000;
  logic [15:0] lfsr_m = SEED;
  logic [23:0] cap_q[$];

  always @(posedge clk) begin
    if (rst) begin
      d1 = 1'b0; d2 = 1'b0;
      high_run = 0; low_run = 0; hold_left = 0; releasing = 1'b0;
      cnt_m = 8'h00; rand_m = 16'h0000; lfsr_m = SEED;
      cap_q.delete();
    end else begin
      x  = d2;
      d2 = d1;
      d1 = btn;
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) begin
          releasing = 1'b1;
          low_run   = 0;
        end
      end else if (releasing) begin
        low_run = x ? 0 : low_run + 1;
        if (low_run == D) begin
          releasing = 1'b0;
          high_run  = 0;
        end
      end else begin
        high_run = x ? high_run + 1 : 0;
        if (high_run == D) begin
          high_run  = 0;
          hold_left = H;
          cnt_m     = cnt_m + 8'd1;
          rand_m    = LFSR_ON ? lfsr_m : 16'h0000;
          cap_q.push_back({cnt_m, rand_m});
        end
      end
      lfsr_m = {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Monitor: whole word every cycle, capture fields whenever a pulse is due.
  bit         mon_en = 1'b0;
  int         pulses_seen = 0;
  logic [23:0] entry;

  always @(negedge clk) begin
    if (mon_en) begin
      check("word", trigger, {cnt_m, rand_m, 7'b0, (hold_left > 0)});
      if (press_pulse) pulses_seen++;
      if (cap_q.size() > 0) begin
        entry = cap_q.pop_front();
        check("pulse", 32'(press_pulse), 32'd1);
        check("capture", 32'(trigger[31:8]), 32'(entry));
      end else begin
        check("pulse", 32'(press_pulse), 32'd0);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  int p0;
  int hc;

  initial begin
    // Reset
    rst = 1'b1;
    btn = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_trigger", trigger, 32'h0);
    check("rst_pulse", 32'(press_pulse), 32'd0);
    rst = 1'b0;
    @(negedge clk);
`ifdef F1_TRIGGER_LFSR_EN
    check("lfsr_first_step", 32'(u_dut.u_lfsr.value), 32'h0000E270);
`endif
    check("post_rst_trigger", trigger, 32'h0);

    // Clean press: btn high before edge 0, inspect after edges 0..13
    btn = 1'b1;
    for (int e = 0; e <= 13; e++) begin
      @(negedge clk);
      check("clean_flag", 32'(trigger[0]), 32'((e >= 5) && (e <= 12)));
      check("clean_pulse", 32'(press_pulse), 32'(e == 5));
      if (e == 5) check("clean_cnt", 32'(trigger[31:24]), 32'd1);
    end
    btn = 1'b0;
    cycles(20);

    // Glitch shorter than the debounce window
    p0  = pulses_seen;
    btn = 1'b1;
    cycles(3);
    btn = 1'b0;
    cycles(20);
    check("glitch_pulses", 32'(pulses_seen - p0), 32'd0);
    check("glitch_cnt", 32'(trigger[31:24]), 32'd1);

    // Held button with a bounce, then a second press
    do_reset();
    p0  = pulses_seen;
    btn = 1'b1; cycles(100);
    btn = 1'b0; cycles(1);
    btn = 1'b1; cycles(99);
    btn = 1'b0; cycles(20);
    btn = 1'b1; cycles(20);
    btn = 1'b0; cycles(30);
    check("held_events", 32'(pulses_seen - p0), 32'd2);
    check("held_cnt", 32'(trigger[31:24]), 32'd2);

    // 256 presses wrap the press counter
    do_reset();
    p0 = pulses_seen;
    repeat (256) begin
      btn = 1'b1; cycles(16);
      btn = 1'b0; cycles(8);
    end
    cycles(10);
    check("wrap_events", 32'(pulses_seen - p0), 32'd256);
    check("wrap_cnt", 32'(trigger[31:24]), 32'd0);

    // Reset during HOLD cycle 3
    btn = 1'b1;
    hc  = 0;
    for (int i = 0; i < 40 && hc < 3; i++) begin
      @(negedge clk);
      if (trigger[0]) hc++;
    end
    check("hold_reached", 32'(hc), 32'd3);
    rst = 1'b1;
    btn = 1'b0;
    @(negedge clk);
    check("rst_mid_hold", trigger, 32'h0);
    check("rst_mid_hold_pulse", 32'(press_pulse), 32'd0);
    rst = 1'b0;
    cycles(10);

    // Randomised button activity
    repeat (300) begin
      btn = 1'($urandom_range(0, 1));
      cycles(int'($urandom_range(1, 12)));
    end
    btn = 1'b0;
    cycles(40);

    check("queue_drained", 32'(cap_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/f1_trigger_gen.md
# f1_trigger_gen

Produces the 32-bit `trigger` word that the F1 pipelined CPU reads as read-only register x5. It synchronises and debounces the asynchronous start push-button and stretches each accepted press into a fixed-length level that a software polling loop cannot miss. It also snapshots a free-running 16-bit LFSR value and an 8-bit press counter so firmware can derive its random light-out delay. The block sits at the top level, between the board button and the register file's `trigger` input.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required to accept a press or a release; legal range ≥2.
- `HOLD_CYCLES`, default 64: clock cycles that `trigger[0]` stays high per accepted press; legal range ≥1.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be non-zero.
- `clk`  in  1: the single clock. All logic is on the posedge.
- `rst`  in  1: reset, synchronous and active-high.
- `btn_in`  in  1: raw asynchronous push-button, active-high.
- `trigger`  out  32: status word read by the CPU as x5.
- `press_pulse`  out  1: one-cycle strobe on each accepted press.

## Operation
- **Synchroniser.** A 2-FF chain on `btn_in` produces `sync`. Only `sync` is sampled by the FSM.
- **FSM states:** IDLE, DEBOUNCE, HOLD, WAIT_RELEASE, with one shared counter `cnt`.
- **IDLE**
  - If `sync`=1, go to DEBOUNCE with `cnt`=1.
- **DEBOUNCE**
  - If `sync`=0, go to IDLE.
  - Else if `cnt`==DEBOUNCE_CYCLES-1, go to HOLD with `cnt`=0. This is the capture event.
  - Else increment `cnt`.
- **HOLD**
  - If `cnt`==HOLD_CYCLES-1, go to WAIT_RELEASE with `cnt`=0.
  - Else increment `cnt`.
  - `sync` is ignored, so HOLD always runs to completion.
- **WAIT_RELEASE**
  - Count consecutive `sync`=0 samples. Any `sync`=1 sample restarts the count at 0.
  - On the DEBOUNCE_CYCLES-th consecutive low sample, go to IDLE.
  - A button held forever therefore yields exactly one trigger.
- **Capture event.** In the same edge:
  - `trigger[23:8]` ← current LFSR value.
  - `trigger[31:24]` ← press count + 1, wrapping 255→0.
  - `press_pulse` = 1 for that one cycle.
- **Trigger word fields.**
  - `trigger[0]` is high exactly while the state is HOLD.
  - `trigger[7:1]` is always 0.
  - `trigger[31:8]` holds its value until the next capture event.
- **LFSR.** 16-bit Galois LFSR that advances every cycle: `next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0)`. It never reaches 0.
- **Reset values.**
  - Synchroniser FFs = 0.
  - State = IDLE, `cnt` = 0.
  - LFSR = LFSR_SEED.
  - `trigger` = 32'h0, `press_pulse` = 0.
  - Reset in any state aborts the operation immediately. An ongoing HOLD is cut short and `trigger[0]` goes low after the reset edge.

## Timing
- All outputs are registered. There is no combinational path from `btn_in`.
- Edge numbering: `btn_in` is stable high and first captured by sync FF1 at edge 0.
  - `sync` is high from edge 1.
  - IDLE samples high at edge 2.
  - The capture event is edge DEBOUNCE_CYCLES+1.
  - `trigger[0]` and `press_pulse` are high after that edge.
- `trigger[0]` falls after edge DEBOUNCE_CYCLES+1+HOLD_CYCLES.
- A glitch yielding fewer than DEBOUNCE_CYCLES consecutive high `sync` samples produces no event and no counter change.
- Minimum press-to-press spacing: HOLD_CYCLES + 2·DEBOUNCE_CYCLES cycles.

## Configuration
- Macro: `F1_TRIGGER_LFSR_EN`.
- **Defined:** the LFSR is present and `trigger[23:8]` captures it as described above.
- **Undefined:** no LFSR flops are built and `trigger[23:8]` is constant 0. All other behaviour and timing are unchanged.

## Structure
- Package `f1_pkg` holds:
  - the state enum `trig_state_t`;
  - `LFSR_TAPS` = 16'hB400;
  - field constants `TRIG_FLAG_BIT` = 0, `TRIG_RAND_LSB` = 8, `TRIG_CNT_LSB` = 24.
- Sub-module `lfsr16` (ports `clk`, `rst`, parameter `SEED`, output `value`), instantiated only under `F1_TRIGGER_LFSR_EN`.
- Counter width is $clog2(max(DEBOUNCE_CYCLES, HOLD_CYCLES)).

## Test plan
All cases use DEBOUNCE_CYCLES=4 and HOLD_CYCLES=8 unless stated otherwise.
- **Reset:** assert `rst` for 2 cycles.
  - Expect `trigger`=0 and `press_pulse`=0.
  - One edge after release, the LFSR equals 16'hE270.
- **Clean press:** `btn_in` high from edge 0.
  - `trigger[0]` is high after edges 5 through 12 and low after edge 13.
  - `press_pulse` is high only after edge 5.
  - `trigger[31:24]`=1.
  - `trigger[23:8]` equals the model LFSR value before edge 5.
- **Glitch:** `btn_in` high for 3 cycles, then low.
  - `trigger` stays 0 and `press_pulse` never fires.
- **Held button:** `btn_in` high for 200 cycles, then released, then pressed again.
  - Exactly 2 events, `trigger[31:24]`=2.
  - A bounce (1-cycle low) during WAIT_RELEASE does not produce an extra event.
- **Wrap and reset mid-HOLD:**
  - 256 clean presses leave `trigger[31:24]`=0.
  - Asserting `rst` at HOLD cycle 3 clears `trigger` on the next edge.
- **Macro undefined:** repeat the clean press.
  - `trigger[23:8]`=0 and all other fields are identical.
